// File: rtl/dig_wr_sched.sv
// Display write scheduler: merges CPU stores, debounced push-buttons and optional auto-scroll
// (enabled by defining SCROLL_EN) into one registered write port for the 7-segment peripheral.
module dig_wr_sched #(
   parameter logic [31:0] DIG_ADDR      = 32'hFFFF_F000,
   parameter int          DEB_CYCLES    = 20000
`ifdef SCROLL_EN
   ,parameter int         SCROLL_CYCLES = 25000000
`endif
) (
   input  logic        clk_to_dig,
   input  logic        rst_to_dig,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  button,
   output logic [31:0] addr_to_dig,
   output logic        we_to_dig,
   output logic [31:0] wdata_to_dig,
   output logic [31:0] cur_value,
   output logic        btn_ovf
);

   localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       stable_q, stable_d;
   logic [DEB_W-1:0] debCnt_q [4];
   logic [DEB_W-1:0] debCnt_d [4];
   logic [3:0]       pressVec;
   logic [1:0]       pressIdx;
   logic             btnValid_q, btnValid_d;
   logic [1:0]       btnIdx_q, btnIdx_d;
   logic             btnOvf_q, btnOvf_d;
   logic [31:0]      addr_q, wdata_q, cur_q;
   logic             we_q;
   logic             cpuHit, issue, issueBtn;
   logic [31:0]      issueData;

   // Button k shows the base pattern rotated right by k nibbles
   function automatic logic [31:0] presetFor(input logic [1:0] k);
      case (k)
         2'd0:    return 32'h1234_5678;
         2'd1:    return 32'h8123_4567;
         2'd2:    return 32'h7812_3456;
         default: return 32'h6781_2345;
      endcase
   endfunction

   always_ff @(posedge clk_to_dig or posedge rst_to_dig) begin
      if (rst_to_dig) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < 4; i++) debCnt_q[i] <= '0;
      end else begin
         sync1_q  <= button;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < 4; i++) debCnt_q[i] <= debCnt_d[i];
      end
   end

   // A press is the cycle a stable level is about to flip from 0 to 1
   always_comb begin
      stable_d = stable_q;
      pressVec = '0;
      for (int i = 0; i < 4; i++) begin
         debCnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (debCnt_q[i] == DEB_MAX) begin
               stable_d[i] = sync2_q[i];
               pressVec[i] = sync2_q[i];
            end else begin
               debCnt_d[i] = debCnt_q[i] + 1'b1;
            end
         end
      end
      pressIdx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pressVec[i]) pressIdx = 2'(i);
      end
   end

`ifdef SCROLL_EN
   localparam int SC_W = (SCROLL_CYCLES > 2) ? $clog2(SCROLL_CYCLES) : 1;
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCROLL_CYCLES - 1);

   logic [SC_W-1:0] scrollCnt_q, scrollCnt_d;
   logic            scrollPend_q, scrollPend_d;
   logic            issueScroll, scrollWrap;

   always_ff @(posedge clk_to_dig or posedge rst_to_dig) begin
      if (rst_to_dig) begin
         scrollCnt_q  <= '0;
         scrollPend_q <= 1'b0;
      end else begin
         scrollCnt_q  <= scrollCnt_d;
         scrollPend_q <= scrollPend_d;
      end
   end

   // A wrap while a step is still pending is absorbed into the same flag
   always_comb begin
      scrollWrap   = (scrollCnt_q == SC_MAX);
      scrollCnt_d  = scrollWrap ? '0 : scrollCnt_q + 1'b1;
      if (issue && !issueScroll) scrollCnt_d = '0;
      scrollPend_d = (scrollPend_q && !issueScroll) || scrollWrap;
   end
`endif

   // Fixed priority: CPU store, then pending button, then pending scroll step
   always_comb begin
      cpuHit    = cpu_we && (cpu_addr == DIG_ADDR);
      issue     = 1'b0;
      issueBtn  = 1'b0;
      issueData = cur_q;
`ifdef SCROLL_EN
      issueScroll = 1'b0;
`endif
      if (cpuHit) begin
         issue     = 1'b1;
         issueData = cpu_wdata;
      end else if (btnValid_q) begin
         issue     = 1'b1;
         issueBtn  = 1'b1;
         issueData = presetFor(btnIdx_q);
      end
`ifdef SCROLL_EN
      else if (scrollPend_q) begin
         issue       = 1'b1;
         issueScroll = 1'b1;
         issueData   = {cur_q[3:0], cur_q[31:4]};
      end
`endif
      btnValid_d = btnValid_q && !issueBtn;
      btnIdx_d   = btnIdx_q;
      btnOvf_d   = btnOvf_q;
      if (|pressVec) begin
         if (btnValid_d) btnOvf_d = 1'b1;
         btnValid_d = 1'b1;
         btnIdx_d   = pressIdx;
      end
   end

   always_ff @(posedge clk_to_dig or posedge rst_to_dig) begin
      if (rst_to_dig) begin
         btnValid_q <= 1'b0;
         btnIdx_q   <= '0;
         btnOvf_q   <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cur_q      <= '0;
      end else begin
         btnValid_q <= btnValid_d;
         btnIdx_q   <= btnIdx_d;
         btnOvf_q   <= btnOvf_d;
         we_q       <= issue;
         if (issue) begin
            addr_q  <= DIG_ADDR;
            wdata_q <= issueData;
            cur_q   <= issueData;
         end
      end
   end

   assign addr_to_dig  = addr_q;
   assign we_to_dig    = we_q;
   assign wdata_to_dig = wdata_q;
   assign cur_value    = cur_q;
   assign btn_ovf      = btnOvf_q;

endmodule

// File: tb/tb_dig_wr_sched.sv
// Randomized self-checking bench for dig_wr_sched against a cycle-level behavioural model;
// define SCROLL_EN to also exercise the auto-scroll source.
module tb_dig_wr_sched;

   localparam logic [31:0] DIG  = 32'hFFFF_F000;
   localparam int          DEB  = 8;
`ifdef SCROLL_EN
   localparam int          SCR  = 16;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpuAddr = '0;
   logic        cpuWe = 1'b0;
   logic [31:0] cpuWdata = '0;
   logic [3:0]  btn = '0;
   logic [31:0] addrOut, wdataOut, curOut;
   logic        weOut, ovfOut;

   int total = 0;
   int bad = 0;
   int writeCount = 0;
   logic [31:0] lastWdata = '0;

   // Reference model state
   logic [3:0]  mPipe1, mPipe2, mLevel;
   int          mRun [4];
   logic        mPendValid, mOvf, mScrollPend;
   int          mPendIdx, mTick;
   logic [31:0] expAddr, expWdata, expCur;
   logic        expWe;

   dig_wr_sched #(
      .DIG_ADDR(DIG),
      .DEB_CYCLES(DEB)
`ifdef SCROLL_EN
      ,.SCROLL_CYCLES(SCR)
`endif
   ) dut (
      .clk_to_dig(clk),
      .rst_to_dig(rst),
      .cpu_addr(cpuAddr),
      .cpu_we(cpuWe),
      .cpu_wdata(cpuWdata),
      .button(btn),
      .addr_to_dig(addrOut),
      .we_to_dig(weOut),
      .wdata_to_dig(wdataOut),
      .cur_value(curOut),
      .btn_ovf(ovfOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] presetOf(input int k);
      logic [31:0] base;
      base = 32'h1234_5678;
      return (base >> (4 * k)) | (base << (32 - 4 * k));
   endfunction

   function automatic void modelReset();
      mPipe1 = '0; mPipe2 = '0; mLevel = '0;
      for (int i = 0; i < 4; i++) mRun[i] = 0;
      mPendValid = 1'b0; mPendIdx = 0; mOvf = 1'b0;
      mScrollPend = 1'b0; mTick = 0;
      expAddr = '0; expWdata = '0; expCur = '0; expWe = 1'b0;
   endfunction

   // One clock edge of the reference behaviour, using the inputs held across that edge
   function automatic void modelStep();
      logic [3:0]  synced, presses;
      logic        wrote, btnIssued, scrollIssued, wrap;
      logic [31:0] data;
      synced = mPipe2;
      presses = '0;
      for (int i = 0; i < 4; i++) begin
         if (synced[i] != mLevel[i]) begin
            mRun[i]++;
            if (mRun[i] == DEB) begin
               mLevel[i] = synced[i];
               mRun[i] = 0;
               presses[i] = synced[i];
            end
         end else begin
            mRun[i] = 0;
         end
      end
      mPipe2 = mPipe1;
      mPipe1 = btn;

      wrote = 1'b0; btnIssued = 1'b0; scrollIssued = 1'b0; data = expCur;
      if (cpuWe && cpuAddr == DIG) begin
         wrote = 1'b1; data = cpuWdata;
      end else if (mPendValid) begin
         wrote = 1'b1; btnIssued = 1'b1; data = presetOf(mPendIdx);
      end else if (mScrollPend) begin
         wrote = 1'b1; scrollIssued = 1'b1; data = (expCur >> 4) | (expCur << 28);
      end

      if (btnIssued) mPendValid = 1'b0;
      if (presses != 0) begin
         if (mPendValid) mOvf = 1'b1;
         mPendValid = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (presses[i]) begin
               mPendIdx = i;
               break;
            end
         end
      end

`ifdef SCROLL_EN
      wrap = (mTick == SCR - 1);
      mTick = wrap ? 0 : mTick + 1;
      if (wrote && !scrollIssued) mTick = 0;
      if (scrollIssued) mScrollPend = 1'b0;
      if (wrap) mScrollPend = 1'b1;
`else
      wrap = 1'b0;
      if (wrap) mScrollPend = 1'b1;
`endif

      expWe = wrote;
      if (wrote) begin
         expAddr = DIG; expWdata = data; expCur = data;
      end
   endfunction

   task automatic compareAll(input string tag);
      checkOutput({tag, ".we"}, {31'b0, weOut}, {31'b0, expWe});
      checkOutput({tag, ".addr"}, addrOut, expAddr);
      checkOutput({tag, ".wdata"}, wdataOut, expWdata);
      checkOutput({tag, ".cur"}, curOut, expCur);
      checkOutput({tag, ".ovf"}, {31'b0, ovfOut}, {31'b0, mOvf});
   endtask

   // Drive one cycle of inputs (called just after a falling edge) and check after the rising edge
   task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] buttons);
      cpuWe = we; cpuAddr = addr; cpuWdata = data; btn = buttons;
      @(posedge clk);
      modelStep();
      #1;
      compareAll(tag);
      if (weOut) begin
         writeCount++;
         lastWdata = wdataOut;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      #2;
      rst = 1'b1;
      cpuWe = 1'b0; btn = '0;
      modelReset();
      #1;
      compareAll("reset");
      repeat (2) @(posedge clk);
      #1;
      compareAll("resetHold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] bState;
      logic       lvl;
      int         runLeft;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int c = 0; c < 6; c++) applyStimulus("idle", 1'b0, DIG, 32'h0, 4'b0);
      applyStimulus("cpuHit", 1'b1, DIG, 32'hDEAD_BEEF, 4'b0);
      applyStimulus("afterHit", 1'b0, DIG, 32'h0, 4'b0);
      applyStimulus("cpuMiss", 1'b1, DIG + 32'd4, 32'h1111_2222, 4'b0);
      applyStimulus("afterMiss", 1'b0, DIG, 32'h0, 4'b0);

      // Bouncing button 2: runs shorter than the debounce window, then a clean hold and release
      writeCount = 0;
      lvl = 1'b0;
      runLeft = 1;
      for (int c = 0; c < 40; c++) begin
         runLeft--;
         if (runLeft == 0) begin
            lvl = ~lvl;
            runLeft = $urandom_range(1, 3);
         end
         applyStimulus("bounce", 1'b0, DIG, 32'h0, {1'b0, lvl, 2'b0});
      end
      for (int c = 0; c < 30; c++) applyStimulus("hold2", 1'b0, DIG, 32'h0, 4'b0100);
      for (int c = 0; c < 30; c++) applyStimulus("release2", 1'b0, DIG, 32'h0, 4'b0000);
      checkOutput("bounceWrites", writeCount, 1);
      checkOutput("bounceData", lastWdata, 32'h7812_3456);

      // Button 1 held while the CPU stores every cycle
      for (int c = 0; c < 22; c++) applyStimulus("cpuStream", 1'b1, DIG, $urandom, 4'b0010);
      applyStimulus("btnAfterStream", 1'b0, DIG, 32'h0, 4'b0010);
      checkOutput("btn1Data", wdataOut, 32'h8123_4567);
      for (int c = 0; c < 20; c++) applyStimulus("release1", 1'b0, DIG, 32'h0, 4'b0);

      // Simultaneous presses, then an overwrite while the CPU keeps the buffer deferred
      writeCount = 0;
      for (int c = 0; c < 20; c++) applyStimulus("press03", 1'b0, DIG, 32'h0, 4'b1001);
      checkOutput("press03Writes", writeCount, 1);
      checkOutput("press03Data", lastWdata, 32'h1234_5678);
      for (int c = 0; c < 20; c++) applyStimulus("release03", 1'b0, DIG, 32'h0, 4'b0);
      for (int c = 0; c < 40; c++)
         applyStimulus("ovfStream", 1'b1, DIG, $urandom, (c < 12) ? 4'b1001 : (c < 24) ? 4'b0000 : 4'b1000);
      checkOutput("ovfSticky", {31'b0, ovfOut}, 32'd1);
      applyStimulus("ovfDrain", 1'b0, DIG, 32'h0, 4'b1000);
      checkOutput("ovfDrainData", wdataOut, 32'h6781_2345);
      for (int c = 0; c < 20; c++) applyStimulus("release3", 1'b0, DIG, 32'h0, 4'b0);

      doReset();
      for (int c = 0; c < 10; c++) applyStimulus("postReset", 1'b0, DIG, 32'h0, 4'b0);

      applyStimulus("scrollSeed", 1'b1, DIG, 32'h1234_5678, 4'b0);
      for (int c = 0; c < 60; c++) applyStimulus("scrollIdle", 1'b0, DIG, 32'h0, 4'b0);

      // Random traffic with slowly toggling buttons and one reset in the middle
      bState = '0;
      for (int c = 0; c < 2400; c++) begin
         logic        we;
         logic [31:0] a;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 19) == 0) bState[i] = ~bState[i];
         we = ($urandom_range(0, 2) == 0);
         a  = ($urandom_range(0, 2) != 0) ? DIG : (($urandom_range(0, 1) == 0) ? DIG + 32'd4 : $urandom);
         applyStimulus("random", we, a, $urandom, bState);
         if (c == 1200) doReset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
